// File: rtl/sr_cmd_gen.sv
// Set/reset command front end: synchronise, debounce and edge-detect two raw buttons, then
// issue single-cycle s/r pulses with a lockout window. Define SR_CMD_PRIORITY_EN for reset priority.
module sr_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 2,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic rst_btn,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PULSE   = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;

  localparam logic [CNT_W:0]   DB_LIM   = (CNT_W+1)'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W:0]   LOCK_LIM = (CNT_W+1)'(LOCKOUT_CYCLES);
  localparam logic [CNT_W:0]   ONE_W    = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  // Channel 0 carries the set request, channel 1 the reset request.
  logic [1:0]       btn_s;
  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0]       db_r;
  logic [1:0]       db_d_r;
  logic [CNT_W-1:0] db_cnt_r [2];
  logic [1:0]       req_s;

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [CNT_W-1:0] lock_cnt_r;
  logic [CNT_W-1:0] lock_cnt_s;
  logic             s_s;
  logic             r_s;
  logic             busy_s;
  logic             conflict_s;

  assign btn_s = {rst_btn, set_btn};
  assign req_s = db_r & ~db_d_r;

  // Two-flop synchronisers, debounce counters/levels and edge-delay registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
      db_r    <= 2'b00;
      db_d_r  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= btn_s;
      sync2_r <= sync1_r;
      db_d_r  <= db_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == db_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (({1'b0, db_cnt_r[i]} + ONE_W) == DB_LIM) begin
          db_r[i]     <= sync2_r[i];
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + ONE_C;
        end
      end
    end
  end

  // Command FSM next-state and next-output decode
  always_comb begin
    state_s    = state_r;
    lock_cnt_s = lock_cnt_r;
    s_s        = 1'b0;
    r_s        = 1'b0;
    conflict_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s == 2'b11) begin
          conflict_s = 1'b1;
`ifdef SR_CMD_PRIORITY_EN
          r_s     = 1'b1;
          state_s = ST_PULSE;
`else
          state_s = ST_IDLE;
`endif
        end else if (req_s[0]) begin
          s_s     = 1'b1;
          state_s = ST_PULSE;
        end else if (req_s[1]) begin
          r_s     = 1'b1;
          state_s = ST_PULSE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PULSE: begin
        lock_cnt_s = '0;
        if (LOCKOUT_CYCLES == 32'sd0) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_LOCKOUT;
        end
      end
      ST_LOCKOUT: begin
        // Requests seen here are dropped: the edge pulse is gone by the time IDLE returns.
        if (({1'b0, lock_cnt_r} + ONE_W) == LOCK_LIM) begin
          lock_cnt_s = '0;
          state_s    = ST_IDLE;
        end else begin
          lock_cnt_s = lock_cnt_r + ONE_C;
          state_s    = ST_LOCKOUT;
        end
      end
      default: begin
        lock_cnt_s = '0;
        state_s    = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // FSM state and registered command outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      lock_cnt_r <= '0;
      s          <= 1'b0;
      r          <= 1'b0;
      busy       <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      state_r    <= state_s;
      lock_cnt_r <= lock_cnt_s;
      s          <= s_s;
      r          <= r_s & ~s_s;
      busy       <= busy_s;
      conflict   <= conflict_s;
    end
  end

endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Command front end for the set/reset flip-flop stage. Takes two raw, asynchronous push-button style inputs (set request, reset request), synchronises and debounces each one, and detects rising edges. It then emits single-cycle `s`/`r` command pulses. The block guarantees the downstream flip-flop never sees `s=1,r=1`, and enforces a lockout window between commands.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required before a debounced level changes (legal range 1..2^CNT_W-1).
- `LOCKOUT_CYCLES`, default 2: idle cycles enforced after each command pulse (legal range 0..2^CNT_W-1).
- `CNT_W`, default 8: width of the debounce and lockout counters.

- `clk` in 1: clock, rising-edge.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `set_btn` in 1: raw set request, asynchronous to `clk`.
- `rst_btn` in 1: raw reset request, asynchronous to `clk`.
- `s` out 1: set command pulse, registered, one cycle wide.
- `r` out 1: reset command pulse, registered, one cycle wide.
- `busy` out 1: high while in PULSE or LOCKOUT.
- `conflict` out 1: one-cycle pulse when both debounced edges occur in the same cycle.

## Operation
- Each input passes through a 2-flop synchroniser (`sync1`, `sync2`) with reset value 0.
- Debounce, per input:
  - A counter counts consecutive cycles with `sync2 != db_level`. It clears whenever `sync2 == db_level`.
  - When the count reaches `DEBOUNCE_CYCLES`, `db_level` takes `sync2` and the counter clears.
- Edge detect: `req_set = db_set & ~db_set_d` (and likewise `req_rst`). `db_*_d` is `db_*` delayed one cycle. Only rising edges generate requests; falling edges are ignored.
- FSM, with states IDLE, PULSE, LOCKOUT:
  - IDLE, `req_set` only: s_next=1, go to PULSE.
  - IDLE, `req_rst` only: r_next=1, go to PULSE.
  - IDLE, both requests: `conflict` pulses and the command depends on configuration (see Configuration). Go to PULSE if a command was issued, otherwise stay in IDLE.
  - PULSE: lasts exactly one cycle, with `s` or `r` high. Next state is LOCKOUT, or IDLE if `LOCKOUT_CYCLES==0`. The lockout counter loads 0.
  - LOCKOUT: counts up and returns to IDLE when the count reaches `LOCKOUT_CYCLES`.
  - Any request arriving in PULSE or LOCKOUT is discarded, not queued.
- Invariant: `s & r` is never 1. At most one of `s`, `r` is high in any cycle.
- Reset: `s=0`, `r=0`, `busy=0`, `conflict=0`. All synchroniser, debounce and edge registers are 0, counters are 0, state is IDLE.
- Reset asserted mid-PULSE or mid-LOCKOUT: all outputs are 0 from the edge after `rst` is sampled high.
- An input held high through reset release produces one pulse after the normal latency, because it is seen as a rising edge from the reset level 0.

## Timing
- Reference point: `set_btn` is stable high before edge N and stays high.
  - `sync2` goes high at N+1.
  - `db_set` goes high at N+1+D, where D=`DEBOUNCE_CYCLES`.
  - `s` rises at edge N+D+2 and falls at N+D+3.
  - With defaults, `s` is high during the cycle after edge N+6.
- `busy` rises with `s`/`r` and falls at the edge where the FSM re-enters IDLE, i.e. after 1+`LOCKOUT_CYCLES` cycles.
  - The next command can be issued at the earliest on the edge after `busy` falls.
- `conflict` is asserted on the same edge a command would have been issued.
- Glitches shorter than D cycles (measured at `sync2`) produce no change in `db_level`.

## Configuration
- `SR_CMD_PRIORITY_EN` defined: simultaneous requests resolve to reset priority. `r` pulses, `s` stays 0, `conflict` pulses, and the FSM goes to PULSE then LOCKOUT as normal.
- `SR_CMD_PRIORITY_EN` undefined: simultaneous requests are both dropped. `conflict` pulses, `s=r=0`, and the FSM stays in IDLE with `busy=0`.

## Test plan
- Reset: hold `rst` for 3 cycles with both inputs 0 -> `s=r=busy=conflict=0` at every sampled edge.
- `set_btn` high at edge N (D=4, L=2):
  - `s=1` only in the cycle after edge N+6, and `r=0` throughout.
  - `busy=1` for 3 cycles.
- Bounce: `set_btn` 1-0-1-0 toggling every 2 cycles, then steady 1 -> exactly one `s` pulse, timed D+2 edges after the last 0→1 transition.
- Request in lockout: `rst_btn` edge whose debounced rise lands 1 cycle after the `s` pulse -> no `r` pulse, `busy` unchanged.
- Simultaneous: both buttons rise on the same edge:
  - Macro defined: `conflict=1` and `r=1` in the same cycle, `s=0`.
  - Macro undefined: `conflict=1`, `s=r=0`, `busy=0`.
- Reset mid-lockout: assert `rst` one cycle after `s` falls -> `busy=0` next edge. A button held through reset yields one fresh pulse D+3 edges after `rst` deasserts.
